hamming_decoder: RTL
====================

# hamming_decoder

Streaming SECDED decoder for the 16-bit Hamming codewords produced by the program-1 encoder path. Accepts codewords as little-endian byte pairs on a valid/ready input. Corrects any single-bit error, flags double-bit errors, and emits the 11 data bits plus a 2-bit status as a byte pair on a valid/ready output. Sits between the data-memory read port and write port of the program-2 datapath, and keeps running error counters for the bench and controller.

## Interface
- `CNT_W`, default 8: width of each error/word counter.

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_byte`  in  8  codeword byte: low byte (bits 7:0) first, then high byte (bits 15:8)
- `in_valid`  in  1  `in_byte` valid
- `in_ready`  out  1  decoder accepts `in_byte` this cycle
- `out_byte`  out  8  result byte: low byte first, then high byte
- `out_valid`  out  1  `out_byte` valid
- `out_ready`  in  1  consumer accepts `out_byte` this cycle
- `word_cnt`  out  CNT_W  words decoded since reset, saturating
- `corr_cnt`  out  CNT_W  words with a single error (corrected), saturating
- `dbl_cnt`  out  CNT_W  words with a double error detected, saturating

## Operation
- Codeword bit i (1..15) is Hamming position i; bit 0 is overall parity p0.
  - Parity bits: p1 = bit1, p2 = bit2, p4 = bit4, p8 = bit8.
  - Data bits: d1 = bit3, d4:d2 = bits 7:5, d11:d5 = bits 15:9.
- Syndrome s[3:0]: s[k] is the XOR of all bits whose position has bit k set. q = XOR of all 16 bits.
- Classification:
  - s=0, q=0: clean, F=00.
  - q=1: single error, F=01. Flip bit s (s=0 means p0 was in error; data unchanged).
  - s≠0, q=0: double error, F=10. Data passes through uncorrected.
- Output bytes:
  - low = d8:d1
  - high = {F[1:0], 3'b000, d11:d9}
- FSM states: IN_LO, IN_HI, DEC, OUT_LO, OUT_HI. Reset state is IN_LO.
  - IN_LO: in_ready=1. On in_valid, latch low byte, go to IN_HI.
  - IN_HI: in_ready=1. On in_valid, latch high byte, go to DEC.
  - DEC: one cycle. Register the corrected data and F, update counters, go to OUT_LO.
  - OUT_LO: out_valid=1, out_byte=low. On out_ready, go to OUT_HI.
  - OUT_HI: out_valid=1, out_byte=high. On out_ready, go to IN_LO.
- in_ready is 0 in DEC, OUT_LO and OUT_HI. Bytes are never dropped or duplicated.
- Counters:
  - word_cnt increments once per DEC.
  - corr_cnt increments on F=01; dbl_cnt on F=10.
  - All three hold at 2^CNT_W−1.

## Timing
- Reset values: in_ready=1 (FSM in IN_LO), out_valid=0, out_byte=0, all counters 0, latched bytes 0.
- A handshake completes when valid and ready are both high on a rising edge.
- Latency: high-byte accept edge → DEC (1 cycle) → out_valid high in the following cycle. That is 2 cycles from the high-byte accept edge to the first out_valid.
- Minimum 5 cycles per word with no stalls. No overlap between input and output phases.
- out_byte and out_valid are registered and stay stable while out_valid=1 and out_ready=0.
- in_valid low in IN_LO or IN_HI: hold state indefinitely.
- Reset asserted mid-word (any state): FSM returns to IN_LO immediately. A partial input word is discarded, pending output is discarded, counters clear.
- Counter update in DEC and a reset on the same edge: reset wins.

## Structure
- Shared package `hamming_pkg` holds:
  - enum `dec_state_t` for the five FSM states
  - status constants `ST_CLEAN`=2'b00, `ST_CORR`=2'b01, `ST_DBL`=2'b10
  - codeword bit-position localparams
  - function `hamming_syndrome`, reusable by the encoder stage
- One natural sub-module: `hamming_correct`, purely combinational. It takes the 16-bit codeword and returns data[11:1] and F[1:0]; DEC registers its outputs.
- The top-level `hamming_decoder` holds the FSM, the byte latches, the output registers and the counters.

## Test plan
- Clean word: bytes 0x0F, 0x00 (codeword 0x000F) → outputs 0x01, 0x00; word_cnt=1, corr_cnt=0, dbl_cnt=0.
- Single data error: codeword 0x020F (d5 flipped, s=9) → outputs 0x01, 0x40; corr_cnt=1.
- p0-only error: codeword 0x000E (s=0, q=1) → outputs 0x01, 0x40; corr_cnt increments.
- Double error: codeword 0x020D (bits 9 and 1 flipped) → outputs 0x11, 0x80; dbl_cnt=1, data not corrected.
- Backpressure: hold out_ready=0 for 7 cycles in OUT_LO → out_byte stays 0x01 with out_valid=1 and in_ready=0; release → 0x01 then 0x00, then in_ready returns to 1.
- Mid-word reset: send low byte 0x0F, pulse reset, then send 0x0F, 0x00 → exactly one output pair 0x01, 0x00 and word_cnt=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared SECDED types, status codes and codeword helpers.
// Used by the decoder and reusable by the encoder stage.
package hamming_pkg;

  typedef enum logic [2:0] {
    IN_LO,
    IN_HI,
    DEC,
    OUT_LO,
    OUT_HI
  } dec_state_t;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_DBL   = 2'b10;

  localparam int P0_POS  = 0;
  localparam int P1_POS  = 1;
  localparam int P2_POS  = 2;
  localparam int P4_POS  = 4;
  localparam int P8_POS  = 8;
  localparam int D1_POS  = 3;
  localparam int D2_POS  = 5;
  localparam int D5_POS  = 9;
  localparam int N_DATA  = 11;

  // Position of data bit k (1..11) inside the codeword.
  function automatic logic [3:0] hamming_pos(input int k);
    int p;
    if (k == 1)
      p = D1_POS;
    else if (k <= 4)
      p = D2_POS + k - 2;
    else
      p = D5_POS + k - 5;
    return p[3:0];
  endfunction

  function automatic logic [3:0] hamming_syndrome(
    input logic [15:0] cw
  );
    logic [3:0] s;
    s = '0;
    for (int i = 1; i < 16; i++)
      if (cw[i]) s ^= i[3:0];
    return s;
  endfunction

endpackage

// File: rtl/hamming_decoder_correct.sv
// Combinational SECDED check: syndrome, overall parity,
// single-bit correction and status classification.
import hamming_pkg::*;

module hamming_correct (
  input  logic [15:0] cw,
  output logic [11:1] data,
  output logic [1:0]  f
);

  logic [3:0] s;
  logic       q;

  assign s = hamming_syndrome(cw);
  assign q = ^cw;

  // A data bit is flipped only when q flags a single error at its position.
  always_comb begin
    data = '0;
    for (int k = 1; k <= N_DATA; k++)
      data[k] = cw[hamming_pos(k)]
              ^ (q && (s == hamming_pos(k)));
  end

  always_comb begin
    f = ST_CLEAN;
    unique case (1'b1)
      q:                  f = ST_CORR;
      (!q && s != 4'd0):  f = ST_DBL;
      default:            f = ST_CLEAN;
    endcase
  end

endmodule

// File: rtl/hamming_decoder.sv
// Byte-streaming SECDED decoder: two bytes in, two bytes out,
// with saturating word/corrected/double-error counters.
import hamming_pkg::*;

module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);

  dec_state_t  state, nxt;
  logic [7:0]  lo_b, hi_b, hi_out;
  logic [11:1] cor_data;
  logic [1:0]  cor_f;

  hamming_correct u_correct (
    .cw   ({hi_b, lo_b}),
    .data (cor_data),
    .f    (cor_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IN_LO;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IN_LO:  if (in_valid)  nxt = IN_HI;
      IN_HI:  if (in_valid)  nxt = DEC;
      DEC:                   nxt = OUT_LO;
      OUT_LO: if (out_ready) nxt = OUT_HI;
      OUT_HI: if (out_ready) nxt = IN_LO;
      default:               nxt = IN_LO;
    endcase
  end

  always_comb begin
    in_ready  = (state == IN_LO) || (state == IN_HI);
    out_valid = (state == OUT_LO) || (state == OUT_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_b     <= '0;
      hi_b     <= '0;
      hi_out   <= '0;
      out_byte <= '0;
      word_cnt <= '0;
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else begin
      if (state == IN_LO && in_valid) lo_b <= in_byte;
      if (state == IN_HI && in_valid) hi_b <= in_byte;
      if (state == DEC) begin
        out_byte <= cor_data[8:1];
        hi_out   <= {cor_f, 3'b000, cor_data[11:9]};
        if (word_cnt != '1)
          word_cnt <= word_cnt + CNT_W'(1);
        if (cor_f == ST_CORR && corr_cnt != '1)
          corr_cnt <= corr_cnt + CNT_W'(1);
        if (cor_f == ST_DBL && dbl_cnt != '1)
          dbl_cnt <= dbl_cnt + CNT_W'(1);
      end
      if (state == OUT_LO && out_ready) out_byte <= hi_out;
    end
  end

endmodule
